step_pulse_gen: RTL

Trapezoidal motion-profile generator that turns absolute position commands into STEP/DIR pulse trains for the downstream `stepdirdriver` half-step phase sequencer. One command moves the motor from the tracked position `POS` to `CMD_TARGET`. The step period ramps from a slow start rate down to a cruise rate and back again. The block sits between the home-automation control logic (curtain, valve and blind actuators) and the phase sequencer.

---
 rtl/step_pulse_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/step_pulse_gen.sv
// Trapezoidal STEP/DIR profile generator: moves POS to an absolute target,
// ramping the step period from START_DIV down to MIN_DIV and back again.
module step_pulse_gen #(
    parameter int POS_W     = 16,
    parameter int DIV_W     = 16,
    parameter int START_DIV = 8,
    parameter int MIN_DIV   = 4,
    parameter int ACCEL_DEC = 2,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [POS_W-1:0] CMD_TARGET,
    input  logic             STOP,
    output logic             STEP,
    output logic             DIR,
    output logic [POS_W-1:0] POS,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam logic [DIV_W-1:0] START_P = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ACC_P   = DIV_W'(ACCEL_DEC);
    localparam logic [DIV_W-1:0] PULSE_P = DIV_W'(PULSE_W);
    localparam logic [DIV_W-1:0] SETUP_P = DIV_W'(DIR_SETUP);

    state_t             state, state_nxt;
    logic [POS_W-1:0]   remaining, remaining_nxt;
    logic [POS_W-1:0]   ramp, ramp_nxt;
    logic [POS_W-1:0]   pos_nxt;
    logic [DIV_W-1:0]   period, period_nxt;
    logic [DIV_W-1:0]   cnt, cnt_nxt;
    logic               step_nxt, dir_nxt, busy_nxt, done_nxt;
    logic               launch;

    logic signed [POS_W:0] delta;
    logic [POS_W-1:0]      distance;
    logic [DIV_W:0]        period_up;
    logic [DIV_W-1:0]      period_up_sat;
    logic [DIV_W-1:0]      period_dn;
    logic [DIV_W-1:0]      low_last;

    // One extra bit keeps the sign correct for full-range moves; the magnitude
    // itself always fits in POS_W bits, so modular subtraction is exact.
    assign delta     = $signed({CMD_TARGET[POS_W-1], CMD_TARGET}) - $signed({POS[POS_W-1], POS});
    assign distance  = delta[POS_W] ? (POS - CMD_TARGET) : (CMD_TARGET - POS);

    assign period_up     = {1'b0, period} + {1'b0, ACC_P};
    assign period_up_sat = (period_up >= {1'b0, START_P}) ? START_P : period_up[DIV_W-1:0];
    assign period_dn     = ((period - MIN_P) >= ACC_P) ? (period - ACC_P) : MIN_P;
    assign low_last      = period - PULSE_P - 1'b1;

    assign CMD_READY = (state == IDLE) && !STOP;

    // Next-state and next-register computation for the whole datapath.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        ramp_nxt      = ramp;
        period_nxt    = period;
        cnt_nxt       = cnt;
        pos_nxt       = POS;
        step_nxt      = STEP;
        dir_nxt       = DIR;
        busy_nxt      = BUSY;
        done_nxt      = 1'b0;
        launch        = 1'b0;

        case (state)
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    if (delta == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        dir_nxt       = !delta[POS_W];
                        remaining_nxt = distance;
                        period_nxt    = START_P;
                        ramp_nxt      = '0;
                        busy_nxt      = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_P - 1'b1) begin
                    launch = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (cnt == PULSE_P - 1'b1) begin
                    step_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = LOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOW: begin
                // The period chosen here is the one the next step will use.
                if (cnt == low_last) begin
                    if (remaining == '0) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (remaining <= ramp) begin
                        period_nxt = period_up_sat;
                        ramp_nxt   = ramp - 1'b1;
                        launch     = 1'b1;
                    end else if (period > MIN_P) begin
                        period_nxt = period_dn;
                        ramp_nxt   = ramp + 1'b1;
                        launch     = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (launch) begin
            step_nxt      = 1'b1;
            pos_nxt       = DIR ? (POS + 1'b1) : (POS - 1'b1);
            remaining_nxt = remaining - 1'b1;
            cnt_nxt       = '0;
            state_nxt     = HIGH;
        end

        // An abort discards any step that would have been launched on this edge.
        if (STOP && (state != IDLE)) begin
            state_nxt     = IDLE;
            step_nxt      = 1'b0;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b0;
            cnt_nxt       = '0;
            pos_nxt       = POS;
            remaining_nxt = remaining;
        end
    end

    // All state lives here; reset clears every register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            ramp      <= '0;
            period    <= '0;
            cnt       <= '0;
            POS       <= '0;
            STEP      <= 1'b0;
            DIR       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            ramp      <= ramp_nxt;
            period    <= period_nxt;
            cnt       <= cnt_nxt;
            POS       <= pos_nxt;
            STEP      <= step_nxt;
            DIR       <= dir_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
        end
    end

endmodule
